// File: rtl/ram_responder.sv
// Word-addressed RAM slave with a memory-mapped output byte register and counter.
// Optional power-up clearing sweep is enabled by defining RAM_CLEAR_ON_RESET_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | clearing sweep in progress, bus traffic ignored, busy_o=1
// ST_RUN  | normal RAM / MMIO service
module ram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  mmio_hit;
  logic                  running;
  logic [7:0]            out_cnt;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  assign word_idx = addr_i[DEPTH_LOG2+1:2];
  assign mmio_hit = (addr_i == MMIO_ADDR);

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] sweep_idx, sweep_idx_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    if (state == ST_INIT) begin
      sweep_idx_nxt = sweep_idx + 1'b1;
      if (sweep_idx == {DEPTH_LOG2{1'b1}}) state_nxt = ST_RUN;
    end
  end

  assign running = (state == ST_RUN);
  assign busy_o  = (state == ST_INIT);
`else
  assign running = 1'b1;
  assign busy_o  = 1'b0;
`endif

  // Single write port shared by the bus and the clearing sweep; no writes during reset.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = word_idx;
    mem_wdata = data_i;
    if (reset) begin
      if (running) begin
        mem_we = we_i && !mmio_hit;
      end
`ifdef RAM_CLEAR_ON_RESET_EN
      else begin
        mem_we    = 1'b1;
        mem_addr  = sweep_idx;
        mem_wdata = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Read-first: the array read below sees the word before this edge's write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_o      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_cnt     <= '0;
    end else if (running) begin
      out_valid_o <= we_i && mmio_hit;
      if (we_i && mmio_hit) begin
        out_data_o <= data_i[7:0];
        out_cnt    <= out_cnt + 8'd1;
      end
      data_o <= mmio_hit ? {24'h0, out_cnt} : mem[word_idx];
    end else begin
      data_o      <= '0;
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of RAM depth in 32-bit words (1024 words).
REQ-002 Parameter MMIO_ADDR, default 32'hFFFF_FFF0: byte address of the output/status register.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 we_i  input  1  write enable from the CPU bus.
REQ-006 addr_i  input  32  byte address from the CPU bus.
REQ-007 data_i  input  32  write data from the CPU bus.
REQ-008 data_o  output  32  registered read data to the CPU bus.
REQ-009 busy_o  output  1  high while the responder ignores bus traffic (init sweep).
REQ-010 out_valid_o  output  1  one-cycle pulse: a byte was written to MMIO_ADDR.
REQ-011 out_data_o  output  8  byte captured by the last MMIO write.

Function
REQ-012 Word index SHALL be addr_i[DEPTH_LOG2+1:2]; addr_i[1:0] and bits above DEPTH_LOG2+1 ignored (aliasing), except for the MMIO decode.
REQ-013 MMIO hit SHALL be an exact 32-bit compare of addr_i with MMIO_ADDR; an MMIO hit never reads or writes the RAM array.
REQ-014 FSM states: INIT, RUN; INIT -> RUN after the last sweep word; RUN -> INIT only via reset.
REQ-015 In RUN, with we_i=1 and no MMIO hit, mem[index] SHALL take data_i at the rising edge.
REQ-016 In RUN, data_o SHALL equal mem[index] sampled at the same edge; one-cycle read latency, every cycle, regardless of we_i.
REQ-017 Read and write to the same index in one cycle SHALL be read-first: data_o returns the old word, the new word is visible on the next read.
REQ-018 In RUN, an MMIO write SHALL load out_data_o with data_i[7:0], pulse out_valid_o high for exactly one cycle, and increment an 8-bit counter out_cnt (255 wraps to 0).
REQ-019 In RUN, an MMIO read SHALL return data_o = {24'h0, out_cnt} with one-cycle latency; on a simultaneous MMIO write, it returns the pre-increment value.
REQ-020 Back-to-back MMIO writes SHALL produce back-to-back out_valid_o pulses, one per write.
REQ-021 In INIT, busy_o=1, data_o=0, out_valid_o=0, and all bus writes (RAM and MMIO) SHALL be dropped.

Reset
REQ-022 While reset=0 at an edge: data_o=0, out_valid_o=0, out_data_o=0, out_cnt=0, sweep index=0.
REQ-023 Reset SHALL NOT directly clear the RAM array; the array is cleared only by the sweep (REQ-025).
REQ-024 Reset asserted mid-sweep or mid-operation SHALL restart from the post-reset state on the next edge; in-flight writes at that edge are dropped.

Configuration
REQ-025 With RAM_CLEAR_ON_RESET_EN defined: after reset, the FSM enters INIT, writes 0 to words 0..2^DEPTH_LOG2-1 at one word per cycle, deasserts busy_o in the cycle after the last word, and enters RUN; the sweep lasts exactly 2^DEPTH_LOG2 cycles after reset release.
REQ-026 Without RAM_CLEAR_ON_RESET_EN: after reset, the FSM enters RUN directly, busy_o is tied to 0, there is no sweep logic, and RAM contents are retained across reset (undefined at power-up).

Verification
REQ-027 Macro defined, DEPTH_LOG2=4: release reset -> busy_o=1 for exactly 16 cycles; a read of addr 0x3C then returns 0.
REQ-028 RUN: write 0xDEADBEEF at 0x10, then read 0x10 -> data_o=0xDEADBEEF one cycle after the read address is presented; read 0x10+(4<<DEPTH_LOG2) -> same value (aliasing).
REQ-029 RUN: simultaneous write 0x12345678 and read at 0x20 holding 0xCAFEF00D -> data_o=0xCAFEF00D; next read -> 0x12345678.
REQ-030 RUN: three consecutive MMIO writes of 0x41, 0x42, 0x43 -> three consecutive out_valid_o pulses, out_data_o=0x43; MMIO read -> data_o=0x00000003; RAM is unchanged.
REQ-031 Macro defined: assert reset at sweep cycle 5 and write at 0x00 during INIT -> sweep restarts at index 0, busy_o is high for the full 2^DEPTH_LOG2 cycles after release, and the write is dropped (read 0x00 -> 0).
